// File: rtl/tinsel_msg_forwarder.sv
// tinsel_msg_forwarder: re-routes multi-flit messages to the NetAddr carried in each head-flit payload
module tinsel_msg_forwarder #(
   parameter int TILE_X      = 0,
   parameter int TILE_Y      = 0,
   parameter int IN_DEPTH    = 4,
   parameter int OUT_DEPTH   = 4,
   parameter int CNT_W       = 32,
   parameter int MESH_X_BITS = 2,
   parameter int MESH_Y_BITS = 2,
   parameter int ADDR_W      = 16,
   parameter int PAY_W       = 32,
   localparam int FLIT_W     = ADDR_W + PAY_W + 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [MESH_X_BITS-1:0] board_x,
   input  logic [MESH_Y_BITS-1:0] board_y,
   input  logic [FLIT_W-1:0]      in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [FLIT_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CNT_W-1:0]       msg_count,
   output logic                   busy
);
   localparam int IA = $clog2(IN_DEPTH);
   localparam int OA = $clog2(OUT_DEPTH);
   typedef enum logic {HEAD, BODY} state_t;
   logic [FLIT_W-1:0] in_mem_q [IN_DEPTH];
   logic [FLIT_W-1:0] out_mem_q [OUT_DEPTH];
   logic [IA:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
   logic [OA:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d, out_vis_q, out_vis_d;
   state_t st_q, st_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic in_empty, in_full, out_full, in_push, out_pop, fwd;
   logic [FLIT_W-1:0] head, fwd_flit;
   logic [PAY_W-1:0] h_pay;
   logic h_nff, h_idle, unused_board;
   assign unused_board = ^{board_x, board_y};
   assign in_empty  = in_wr_q == in_rd_q;
   assign in_full   = (in_wr_q[IA] != in_rd_q[IA]) && (in_wr_q[IA-1:0] == in_rd_q[IA-1:0]);
   assign out_full  = (out_wr_q[OA] != out_rd_q[OA]) && (out_wr_q[OA-1:0] == out_rd_q[OA-1:0]);
   assign in_ready  = !rst && !in_full;
   // Written output entries become readable one cycle later, like a mailbox memory read port
   assign out_valid = out_vis_q != out_rd_q;
   assign out_data  = out_mem_q[out_rd_q[OA-1:0]];
   assign in_push   = in_valid && in_ready;
   assign out_pop   = out_valid && out_ready;
   assign fwd       = !in_empty && !out_full;
   assign head      = in_mem_q[in_rd_q[IA-1:0]];
   assign {h_pay, h_nff, h_idle} = head[PAY_W+1:0];
   assign fwd_flit  = h_idle ? head : {st_q == BODY ? dest_q : h_pay[ADDR_W-1:0], h_pay, h_nff, 1'b0};
   assign msg_count = cnt_q;
   assign busy      = !in_empty || (out_wr_q != out_rd_q) || st_q == BODY;
   // Next-state: pointer advance, message FSM, latched destination, completed-message count
   always_comb begin
      in_wr_d   = in_wr_q + {{IA{1'b0}}, in_push};
      in_rd_d   = in_rd_q + {{IA{1'b0}}, fwd};
      out_wr_d  = out_wr_q + {{OA{1'b0}}, fwd};
      out_rd_d  = out_rd_q + {{OA{1'b0}}, out_pop};
      out_vis_d = out_wr_q;
      cnt_d     = cnt_q + {{CNT_W-1{1'b0}}, out_pop && !out_data[1] && !out_data[0]};
      st_d      = (fwd && !h_idle) ? (h_nff ? BODY : HEAD) : st_q;
      dest_d    = (fwd && !h_idle && st_q == HEAD && h_nff) ? h_pay[ADDR_W-1:0] : dest_q;
   end
   // State register; reset empties both FIFOs and abandons any message in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_wr_q   <= '0;
         in_rd_q   <= '0;
         out_wr_q  <= '0;
         out_rd_q  <= '0;
         out_vis_q <= '0;
         st_q      <= HEAD;
         dest_q    <= '0;
         cnt_q     <= '0;
      end else begin
         in_wr_q   <= in_wr_d;
         in_rd_q   <= in_rd_d;
         out_wr_q  <= out_wr_d;
         out_rd_q  <= out_rd_d;
         out_vis_q <= out_vis_d;
         st_q      <= st_d;
         dest_q    <= dest_d;
         cnt_q     <= cnt_d;
      end
   end
   // FIFO storage needs no reset: pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (in_push) in_mem_q[in_wr_q[IA-1:0]] <= in_data;
      if (fwd) out_mem_q[out_wr_q[OA-1:0]] <= fwd_flit;
   end
endmodule

// File: tb/tb_tinsel_msg_forwarder.sv
// tb_tinsel_msg_forwarder: directed and random checks of message re-routing against a queue model
module tb_tinsel_msg_forwarder;
   typedef logic [49:0] flit_t;
   logic clk = 0, rst = 1;
   logic [1:0] board_x = 2'd1, board_y = 2'd2;
   flit_t in_data = '0, out_data;
   logic in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
   logic [3:0] msg_count;
   int passed = 0, total = 0;
   flit_t exp_q[$], out_log[$];
   logic [3:0] m_cnt = 0;
   logic m_in_msg = 0;
   logic [15:0] m_dest = 0;

   tinsel_msg_forwarder #(.TILE_X(3), .TILE_Y(1), .IN_DEPTH(4), .OUT_DEPTH(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .board_x(board_x), .board_y(board_y),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .msg_count(msg_count), .busy(busy));

   always #5 clk = ~clk;

   function automatic flit_t mk(input logic [15:0] d, input logic [31:0] p, input logic nff, input logic idle);
      return {d, p, nff, idle};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
   endtask

   // Model: output flit per accepted input flit, derived from message framing; count per final flit out
   always @(negedge clk) if (!rst) begin
      chk("msg_count", {60'd0, msg_count}, {60'd0, m_cnt});
      if (out_valid) begin
         if (exp_q.size() == 0) chk("out_valid_unexpected", {63'd0, out_valid}, 64'd0);
         else begin
            chk("out_data", {14'd0, out_data}, {14'd0, exp_q[0]});
            if (out_ready) begin
               out_log.push_back(out_data);
               if (!exp_q[0][1] && !exp_q[0][0]) m_cnt = m_cnt + 4'd1;
               void'(exp_q.pop_front());
            end
         end
      end
      if (in_valid && in_ready) begin
         if (in_data[0]) exp_q.push_back(in_data);
         else if (!m_in_msg) begin
            exp_q.push_back(mk(in_data[17:2], in_data[33:2], in_data[1], 1'b0));
            m_in_msg = in_data[1];
            m_dest = in_data[17:2];
         end else begin
            exp_q.push_back(mk(m_dest, in_data[33:2], in_data[1], 1'b0));
            m_in_msg = in_data[1];
         end
      end
   end

   task automatic send(input flit_t f);
      int n = 0;
      logic acc;
      in_data = f;
      in_valid = 1;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      in_valid = 0;
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1;
      while ((exp_q.size() != 0 || out_valid) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_left", exp_q.size(), 64'd0);
   endtask

   initial begin
      #200_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int idx, l0;
      #2;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_count", {60'd0, msg_count}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      #1 chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
      // T1: single-flit message, visible two edges after the accepting edge
      out_ready = 1;
      send(mk(16'h0999, 32'hABCD0123, 1'b0, 1'b0));
      chk("t1_lat0", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      chk("t1_lat1", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
      chk("t1_lat2", {63'd0, out_valid}, 64'd1);
      chk("t1_data", {14'd0, out_data}, {14'd0, mk(16'h0123, 32'hABCD0123, 1'b0, 1'b0)});
      @(posedge clk); #1;
      chk("t1_count", {60'd0, msg_count}, 64'd1);
      // T2: three-flit message, body low bits must not be taken as an address
      l0 = out_log.size();
      send(mk(16'h0000, 32'h55550040, 1'b1, 1'b0));
      send(mk(16'h0000, 32'h12340FFF, 1'b1, 1'b0));
      send(mk(16'h0000, 32'h00000FFF, 1'b0, 1'b0));
      drain();
      chk("t2_f0", {14'd0, out_log[l0]}, {14'd0, mk(16'h0040, 32'h55550040, 1'b1, 1'b0)});
      chk("t2_f1", {14'd0, out_log[l0+1]}, {14'd0, mk(16'h0040, 32'h12340FFF, 1'b1, 1'b0)});
      chk("t2_f2", {14'd0, out_log[l0+2]}, {14'd0, mk(16'h0040, 32'h00000FFF, 1'b0, 1'b0)});
      chk("t2_count", {60'd0, msg_count}, 64'd2);
      // T3: backpressure fills exactly both FIFOs, then drains one per cycle
      out_ready = 0;
      idx = 0;
      l0 = out_log.size();
      for (int c = 0; c < 30; c++) begin
         in_valid = idx < 20;
         in_data = mk(16'h0, 32'h100 + idx, 1'b0, 1'b0);
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
      end
      chk("t3_accepted", idx, 64'd8);
      chk("t3_in_ready", {63'd0, in_ready}, 64'd0);
      out_ready = 1;
      for (int c = 0; c < 20; c++) begin
         in_valid = idx < 20;
         in_data = mk(16'h0, 32'h100 + idx, 1'b0, 1'b0);
         @(negedge clk);
         chk("t3_b2b", {63'd0, out_valid}, 64'd1);
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
      end
      in_valid = 0;
      drain();
      for (int i = 0; i < 20; i++) chk("t3_order", {32'd0, out_log[l0+i][33:2]}, 64'h100 + i);
      // T4: idle token inside a message passes verbatim and leaves routing alone
      l0 = out_log.size();
      send(mk(16'h0000, 32'h00000222, 1'b1, 1'b0));
      send(mk(16'h0000, 32'h00000001, 1'b1, 1'b0));
      send(mk(16'h0777, 32'hDEAD0000, 1'b0, 1'b1));
      send(mk(16'h0000, 32'h00000002, 1'b0, 1'b0));
      drain();
      chk("t4_tok", {14'd0, out_log[l0+2]}, {14'd0, mk(16'h0777, 32'hDEAD0000, 1'b0, 1'b1)});
      chk("t4_tail", {14'd0, out_log[l0+3]}, {14'd0, mk(16'h0222, 32'h00000002, 1'b0, 1'b0)});
      chk("t4_count", {60'd0, msg_count}, 64'd7);
      // T5: asynchronous reset mid-message with both FIFOs occupied
      out_ready = 0;
      send(mk(16'h0000, 32'h00000333, 1'b1, 1'b0));
      for (int i = 0; i < 5; i++) send(mk(16'h0000, 32'h00000010 + i, 1'b1, 1'b0));
      chk("t5_busy_pre", {63'd0, busy}, 64'd1);
      @(posedge clk);
      #2 rst = 1;
      #1;
      chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
      chk("t5_busy", {63'd0, busy}, 64'd0);
      chk("t5_count", {60'd0, msg_count}, 64'd0);
      chk("t5_in_ready", {63'd0, in_ready}, 64'd0);
      exp_q.delete();
      m_cnt = 0;
      m_in_msg = 0;
      #1 rst = 0;
      @(posedge clk); #1;
      out_ready = 1;
      send(mk(16'h0000, 32'h00000456, 1'b0, 1'b0));
      drain();
      chk("t5_head", {14'd0, out_log[out_log.size()-1]}, {14'd0, mk(16'h0456, 32'h00000456, 1'b0, 1'b0)});
      // T6: counter wraps at 2^4 (1 + 16 messages)
      for (int i = 0; i < 16; i++) send(mk(16'h0000, 32'h00000500 + i, 1'b0, 1'b0));
      drain();
      chk("t6_wrap", {60'd0, msg_count}, 64'd1);
      // T6: random valid/ready traffic checked by the model every cycle
      idx = 0;
      in_data = mk(16'($urandom), $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
      while (idx < 10000) begin
         in_valid = $urandom_range(0, 9) < 7;
         out_ready = $urandom_range(0, 9) < 7;
         @(negedge clk);
         if (in_valid && in_ready) begin
            idx++;
            @(posedge clk); #1;
            in_data = mk(16'($urandom), $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
         end else begin
            @(posedge clk); #1;
         end
      end
      in_valid = 0;
      drain();
      @(posedge clk); #1;
      chk("t6_idle_out", {63'd0, out_valid}, 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
